// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the demux_stream block.
//   DEMUX_CH0 / DEMUX_CH1 : values of in_sel that pick channel 0 / channel 1.
//   cnt_t                 : 8-bit per-channel accepted-word counter type.
package demux_pkg;
  localparam logic DEMUX_CH0 = 1'b0;
  localparam logic DEMUX_CH1 = 1'b1;

  typedef logic [7:0] cnt_t;
endpackage

// File: rtl/demux_fifo.sv
// demux_fifo
//   Single-clock synchronous FIFO holding one demux channel.
//   Ports:
//     clk      : clock, all state changes on the rising edge
//     reset_n  : synchronous active-low reset (pointers and fill to 0)
//     i_push   : write i_data this cycle (ignored while full)
//     i_pop    : retire the head word this cycle (ignored while empty)
//     i_data   : word to write
//     o_data   : head word, combinational read of registered storage
//     o_full   : fill == DEPTH
//     o_empty  : fill == 0
//   Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2).
module demux_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [FW-1:0]    r_fill;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_fill == '0);
  assign o_full    = (r_fill == FILL_MAX);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Storage is not reset: stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/demux_stream.sv
// demux_stream
//   Registered 1-to-2 stream demultiplexer. Each accepted input word is
//   steered by in_sel into one of two independent channel FIFOs.
//   Ports:
//     clk, reset_n            : clock, synchronous active-low reset
//     in_data/in_sel          : input word and destination channel
//     in_valid/in_ready       : input handshake
//     out0_data/valid/ready   : channel 0 output handshake
//     out1_data/valid/ready   : channel 1 output handshake
//     cnt0/cnt1               : accepted-word counters (only with DEMUX_COUNT_EN)
//   Optional feature macro: DEMUX_COUNT_EN adds the cnt0/cnt1 ports and counters.
//
//   Handshake: a word moves on a rising edge exactly when valid & ready are both
//   high; valid never depends on ready. in_ready is derived only from in_sel and
//   the registered fill of the selected channel, so a full channel refuses a
//   word even if it pops in the same cycle.
module demux_stream #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
`endif
);
  import demux_pkg::*;

  logic w_full0;
  logic w_full1;
  logic w_empty0;
  logic w_empty1;
  logic w_accept;
  logic w_push0;
  logic w_push1;
  logic w_pop0;
  logic w_pop1;

  // Only the selected channel's full flag matters: no head-of-line blocking.
  assign in_ready   = (in_sel == DEMUX_CH1) ? ~w_full1 : ~w_full0;
  assign w_accept   = in_valid & in_ready;
  assign w_push0    = w_accept & (in_sel == DEMUX_CH0);
  assign w_push1    = w_accept & (in_sel == DEMUX_CH1);

  assign out0_valid = ~w_empty0;
  assign out1_valid = ~w_empty1;
  assign w_pop0     = out0_valid & out0_ready;
  assign w_pop1     = out1_valid & out1_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push0),
    .i_pop   (w_pop0),
    .i_data  (in_data),
    .o_data  (out0_data),
    .o_full  (w_full0),
    .o_empty (w_empty0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push1),
    .i_pop   (w_pop1),
    .i_data  (in_data),
    .o_data  (out1_data),
    .o_full  (w_full1),
    .o_empty (w_empty1)
  );

`ifdef DEMUX_COUNT_EN
  cnt_t r_cnt0;
  cnt_t r_cnt1;

  // 8-bit counters wrap 255 -> 0 by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_push1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif
endmodule

// File: doc/demux_stream.md
# demux_stream

Registered 1-to-2 stream demultiplexer with valid/ready handshake: the splitting counterpart of the 2-bit, 2-input `mux` selector. Each accepted input word is steered by `in_sel` into one of two per-channel FIFOs. Each FIFO drains independently to its own downstream consumer. Sits between a single producer and two consumers on the lab datapath.

## Interface
Parameters:
- `WIDTH`, 2: data width per word.
- `DEPTH`, 2: entries per channel FIFO; power of two, ≥ 2.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` input 1: clock; all state changes on its rising edge.
- `reset_n` input 1: synchronous active-low reset, sampled on the `clk` rising edge.
- `in_data` input WIDTH: input word.
- `in_sel` input 1: destination; 0 → channel 0, 1 → channel 1.
- `in_valid` input 1: producer has a word.
- `in_ready` output 1: demux accepts the word this cycle.
- `out0_data` output WIDTH: channel 0 head word.
- `out0_valid` output 1: channel 0 non-empty.
- `out0_ready` input 1: channel 0 consumer takes the head.
- `out1_data` output WIDTH: channel 1 head word.
- `out1_valid` output 1: channel 1 non-empty.
- `out1_ready` input 1: channel 1 consumer takes the head.
- `cnt0` output 8: channel 0 accepted-word count. Present only with `DEMUX_COUNT_EN`.
- `cnt1` output 8: channel 1 accepted-word count. Present only with `DEMUX_COUNT_EN`.

## Operation
- Per-channel state:
  - `rd_ptr`, `wr_ptr`: log2(DEPTH) bits, wrap modulo DEPTH.
  - `fill`: 0..DEPTH.
  - `empty` = (fill==0); `full` = (fill==DEPTH).
- Input ready: `in_ready` = ~full of the channel named by `in_sel`. This is combinational from `in_sel` and registered fill only, never from `out*_ready`.
- Push: when `in_valid & in_ready`, write `in_data` at `wr_ptr` of the selected channel and increment `wr_ptr`. The other channel is untouched.
- Pop: when `outN_valid & outN_ready`, increment `rd_ptr` of channel N.
- Output: `outN_valid` = ~empty; `outN_data` = mem[rd_ptr], combinational read of registered storage.
- Fill update per channel:
  - push only: +1.
  - pop only: −1.
  - push and pop same cycle: unchanged.
- Full channel: `in_ready`=0 even if the same channel pops that cycle; no bypass of the full check.
- Empty channel: `outN_data` holds the last-read location, value don't-care; `outN_valid`=0.
- Independent channels: a full channel 0 does not block words for channel 1 (no head-of-line blocking across `in_sel` values).
- `in_data` with `in_valid`=0 is ignored regardless of `in_sel`.

## Timing
- Reset (`reset_n`=0 at edge): all pointers and fills go to 0. Counters go to 0.
- Reset values of outputs: `out0_valid`=`out1_valid`=0 and `in_ready`=1 from the cycle after reset.
- Reset mid-operation flushes both FIFOs. Stored words are lost and are not presented after reset.
- Latency: a word accepted at edge k is visible on `outN_data`/`outN_valid` after edge k (1 cycle).
- Throughput: 1 word/cycle per channel with no backpressure.
- Order is preserved within a channel. There is no ordering guarantee across channels.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - `cnt0`/`cnt1` exist.
  - Each increments by 1 on every accepted push to its channel.
  - Wraps 255→0.
  - Reset to 0.
- `DEMUX_COUNT_EN` undefined: the count ports and their registers are absent. Datapath behaviour is identical.

## Structure
- Shared package `demux_pkg`:
  - `DEMUX_CH0`=1'b0 and `DEMUX_CH1`=1'b1 select constants.
  - `cnt_t` (8-bit counter type).
- One sub-module `demux_fifo`: a single-clock sync FIFO with params WIDTH/DEPTH, push/pop, data, full/empty, and `reset_n`. The top instantiates it twice and holds only steering, ready, and counter logic.

## Test plan
- Reset then idle: `reset_n`=0 for 2 cycles → `out0_valid`=`out1_valid`=0, `in_ready`=1, `cnt0`=`cnt1`=0.
- Steering: push 2'b01 sel=0, then 2'b10 sel=1, outputs ready=1 → `out0_data`=01 one cycle after the first push, `out1_data`=10 one cycle after the second; `cnt0`=`cnt1`=1.
- Full and backpressure: `out0_ready`=0, push 3,2,1 with sel=0 → first two accepted, `in_ready`=0 on the third. With sel=1 in that same cycle, `in_ready`=1. Channel 0 then drains in order 3,2.
- Full with same-cycle pop: channel 0 full, `out0_ready`=1, push sel=0 → `in_ready`=0; fill drops to 1 and the word is accepted next cycle.
- Reset mid-stream: channel 1 holds 2 words, `reset_n`=0 one cycle → `out1_valid`=0 afterward; new push 2'b11 sel=1 appears next cycle.
- Counter wrap (`DEMUX_COUNT_EN`): 256 pushes to channel 0 with `out0_ready`=1 → `cnt0`=0, `cnt1` unchanged.
